pythag_leg_solver: RTL and testbench

Sequential inverse-Pythagoras unit: given a hypotenuse `h` and one leg `a`, it returns the other leg `b = floor(sqrt(h² − a²))`, plus an exactness flag and an error flag. It is the reverse-direction companion of the addon's hypotenuse datapath (`sqrt(x² + y²)`), and sits behind the same 8-bit operand buses. It is built from a shift-add squarer and a restoring digit-by-digit square root. Latency is fixed and does not depend on the data.

---
 rtl/pythag_leg_solver_if.sv | 34 +++
 rtl/pythag_leg_solver.sv | 180 ++++++++++++++++++
 tb/tb_pythag_leg_solver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pythag_leg_solver_if.sv
// ----------------------------------------------------------------------------
// pythag_leg_solver_if
// Operand/result bundle for the inverse-Pythagoras unit.
//   start : request pulse, only honoured while the unit is idle
//   h, a  : hypotenuse and known leg (unsigned, W bits), latched on accept
//   busy  : high from the accept edge until done is deasserted
//   done  : one-cycle pulse; b/exact/err valid from this cycle onward
//   b     : floor(sqrt(h^2 - a^2))
//   exact : h^2 - a^2 is a perfect square
//   err   : a > h (b and exact forced to 0)
// Modports: master drives the request, slave is the solver.
// ----------------------------------------------------------------------------
interface pythag_leg_solver_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] h;
    logic [W-1:0] a;
    logic         busy;
    logic         done;
    logic [W-1:0] b;
    logic         exact;
    logic         err;

    modport master (
        output start, h, a,
        input  busy, done, b, exact, err
    );

    modport slave (
        input  start, h, a,
        output busy, done, b, exact, err
    );
endinterface

// File: rtl/pythag_leg_solver.sv
// ----------------------------------------------------------------------------
// pythag_leg_solver
// Sequential b = floor(sqrt(h^2 - a^2)) with exactness and error flags.
// Two shift-add squarers run in parallel (W cycles), one subtract cycle,
// then a restoring digit-by-digit square root (W cycles, 2 bits per cycle).
// Latency is fixed: done is high 2W+2 cycles after the accept edge.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any operation in flight
//   bus : pythag_leg_solver_if slave modport (start/h/a in, results out)
// ----------------------------------------------------------------------------
module pythag_leg_solver #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pythag_leg_solver_if.slave    bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_SUB,
        S_ROOT,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_h;
    logic [W-1:0]     r_a;

    // Index 0 squares h, index 1 squares a.
    logic [2*W-1:0]   r_mcand [2];
    logic [W-1:0]     r_mult  [2];
    logic [2*W-1:0]   r_sq    [2];
    logic [2*W-1:0]   w_sq_next [2];

    logic             r_err_int;
    logic [2*W-1:0]   r_d;
    logic [W+1:0]     r_rem;
    logic [W-1:0]     r_root;

    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_b;
    logic             r_exact;
    logic             r_err;

    // One shift-add step per squarer: add the shifted multiplicand when the
    // current multiplier LSB is set.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sq
            assign w_sq_next[gi] = r_sq[gi] + (r_mult[gi][0] ? r_mcand[gi] : '0);
        end
    endgenerate

    // Restoring root step: bring down the next pair of d and try to subtract
    // 4*root + 1. The kept remainder never exceeds 2*root, so W+2 bits hold it.
    logic [1:0]       w_pair;
    logic [W+3:0]     w_shift;
    logic [W+3:0]     w_sub;
    logic             w_ge;
    logic [W+1:0]     w_trial;
    logic [W+1:0]     w_rem_next;
    logic [W-1:0]     w_root_next;

    assign w_pair      = r_d[2*W-1 -: 2];
    assign w_shift     = {r_rem, w_pair};
    assign w_sub       = {2'b00, r_root, 2'b01};
    assign w_ge        = (w_shift >= w_sub);
    assign w_trial     = w_shift[W+1:0] - w_sub[W+1:0];
    assign w_rem_next  = w_ge ? w_trial : w_shift[W+1:0];
    assign w_root_next = {r_root[W-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_h       <= '0;
            r_a       <= '0;
            for (int i = 0; i < 2; i++) begin
                r_mcand[i] <= '0;
                r_mult[i]  <= '0;
                r_sq[i]    <= '0;
            end
            r_err_int <= 1'b0;
            r_d       <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_b       <= '0;
            r_exact   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_h        <= bus.h;
                        r_a        <= bus.a;
                        r_mcand[0] <= {{W{1'b0}}, bus.h};
                        r_mult[0]  <= bus.h;
                        r_mcand[1] <= {{W{1'b0}}, bus.a};
                        r_mult[1]  <= bus.a;
                        r_sq[0]    <= '0;
                        r_sq[1]    <= '0;
                        r_cnt      <= CW'(W - 1);
                        r_busy     <= 1'b1;
                        r_b        <= '0;
                        r_exact    <= 1'b0;
                        r_err      <= 1'b0;
                        r_state    <= S_MUL;
                    end
                end

                S_MUL: begin
                    for (int i = 0; i < 2; i++) begin
                        r_sq[i]    <= w_sq_next[i];
                        r_mcand[i] <= r_mcand[i] << 1;
                        r_mult[i]  <= r_mult[i] >> 1;
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_SUB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_SUB: begin
                    // Direct operand compare; forcing d to 0 keeps the root
                    // datapath free of negative values.
                    r_err_int <= (r_a > r_h);
                    r_d       <= (r_a > r_h) ? '0 : (r_sq[0] - r_sq[1]);
                    r_rem     <= '0;
                    r_root    <= '0;
                    r_cnt     <= CW'(W - 1);
                    r_state   <= S_ROOT;
                end

                S_ROOT: begin
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_d    <= r_d << 2;
                    if (r_cnt == '0) begin
                        // Results are registered on the edge entering FIN so
                        // that done and the data are visible together.
                        r_b     <= w_root_next;
                        r_exact <= (w_rem_next == '0) & ~r_err_int;
                        r_err   <= r_err_int;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.b     = r_b;
    assign bus.exact = r_exact;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_pythag_leg_solver.sv
// ----------------------------------------------------------------------------
// tb_pythag_leg_solver
// Directed tests for pythag_leg_solver: reset, known vectors, extremes,
// error case, busy-time input changes, back-to-back requests, reset during
// an operation, and a sampled sweep of h/a against a local integer model.
// Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_pythag_leg_solver;
    localparam int W   = 8;
    localparam int LAT = 18;   // cycles from accept edge to the done cycle
    localparam int TMO = 40;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pythag_leg_solver_if #(.W(W)) bus ();

    pythag_leg_solver #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int isqrt(input int d);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= d) r++;
        return r;
    endfunction

    // Issue one request and wait (bounded) for done. lat is the cycle number
    // in which done was seen, counting the cycle after the accept edge as 1.
    task automatic do_op(input int hv, input int av,
                         output int ob, output int oe, output int oerr,
                         output int olat);
        @(negedge clk);
        bus.h     = 8'(hv);
        bus.a     = 8'(av);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        olat = 1;
        while (bus.done !== 1'b1 && olat < TMO) begin
            @(negedge clk);
            olat++;
        end
        ob   = int'(bus.b);
        oe   = int'(bus.exact);
        oerr = int'(bus.err);
        $display("op h=%0d a=%0d -> b=%0d exact=%0d err=%0d lat=%0d",
                 hv, av, ob, oe, oerr, olat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.b !== 8'd0) begin errors++; $display("FAIL reset_b: got %0d want 0", bus.b); end
        checks++; if (bus.exact !== 1'b0) begin errors++; $display("FAIL reset_exact: got %b want 0", bus.exact); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    endtask

    task automatic test_basic();
        int b, e, er, lat;
        do_op(5, 3, b, e, er, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_lat: got %0d want %0d", lat, LAT); end
        checks++; if (b !== 4) begin errors++; $display("FAIL basic_b: got %0d want 4", b); end
        checks++; if (e !== 1) begin errors++; $display("FAIL basic_exact: got %0d want 1", e); end
        checks++; if (er !== 0) begin errors++; $display("FAIL basic_err: got %0d want 0", er); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", bus.busy); end
        checks++; if (bus.b !== 8'd4) begin errors++; $display("FAIL basic_b_hold: got %0d want 4", bus.b); end
    endtask

    task automatic test_extremes();
        int b, e, er, lat;
        do_op(255, 0, b, e, er, lat);
        checks++; if (b !== 255 || e !== 1 || er !== 0 || lat !== LAT) begin errors++;
            $display("FAIL ext_255_0: got b=%0d exact=%0d err=%0d lat=%0d want 255 1 0 %0d", b, e, er, lat, LAT); end
        do_op(255, 1, b, e, er, lat);
        checks++; if (b !== 254 || e !== 0 || er !== 0 || lat !== LAT) begin errors++;
            $display("FAIL ext_255_1: got b=%0d exact=%0d err=%0d lat=%0d want 254 0 0 %0d", b, e, er, lat, LAT); end
        do_op(10, 10, b, e, er, lat);
        checks++; if (b !== 0 || e !== 1 || er !== 0 || lat !== LAT) begin errors++;
            $display("FAIL ext_10_10: got b=%0d exact=%0d err=%0d lat=%0d want 0 1 0 %0d", b, e, er, lat, LAT); end
    endtask

    task automatic test_nonsquare_err();
        int b, e, er, lat;
        do_op(7, 2, b, e, er, lat);
        checks++; if (b !== 6 || e !== 0 || er !== 0 || lat !== LAT) begin errors++;
            $display("FAIL nonsq_7_2: got b=%0d exact=%0d err=%0d lat=%0d want 6 0 0 %0d", b, e, er, lat, LAT); end
        do_op(10, 11, b, e, er, lat);
        checks++; if (b !== 0 || e !== 0 || er !== 1 || lat !== LAT) begin errors++;
            $display("FAIL err_10_11: got b=%0d exact=%0d err=%0d lat=%0d want 0 0 1 %0d", b, e, er, lat, LAT); end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        @(negedge clk);
        bus.h = 8'd5; bus.a = 8'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", bus.busy); end
        while (bus.done !== 1'b1 && cyc < TMO) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin bus.h = 8'd7; bus.a = 8'd2; bus.start = 1'b1; end
            if (cyc == 6) bus.start = 1'b0;
        end
        $display("op h=5 a=3 (changed while busy) -> b=%0d exact=%0d err=%0d lat=%0d",
                 bus.b, bus.exact, bus.err, cyc);
        checks++; if (cyc !== LAT) begin errors++; $display("FAIL ignore_lat: got %0d want %0d", cyc, LAT); end
        checks++; if (bus.b !== 8'd4 || bus.exact !== 1'b1 || bus.err !== 1'b0) begin errors++;
            $display("FAIL ignore_result: got b=%0d exact=%b err=%b want 4 1 0", bus.b, bus.exact, bus.err); end
    endtask

    task automatic test_back_to_back();
        int b, e, er, lat;
        do_op(5, 3, b, e, er, lat);
        checks++; if (b !== 4 || lat !== LAT) begin errors++;
            $display("FAIL b2b_first: got b=%0d lat=%0d want 4 %0d", b, lat, LAT); end
        // The next request is raised in the cycle right after done.
        do_op(7, 2, b, e, er, lat);
        checks++; if (b !== 6 || e !== 0 || er !== 0 || lat !== LAT) begin errors++;
            $display("FAIL b2b_second: got b=%0d exact=%0d err=%0d lat=%0d want 6 0 0 %0d", b, e, er, lat, LAT); end
    endtask

    task automatic test_reset_midop();
        int b, e, er, lat, cyc, seen;
        @(negedge clk);
        bus.h = 8'd13; bus.a = 8'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 9) begin @(negedge clk); cyc++; end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.b !== 8'd0 || bus.exact !== 1'b0 || bus.err !== 1'b0) begin errors++;
            $display("FAIL midop_reset_outputs: got busy=%b done=%b b=%0d exact=%b err=%b want all 0",
                     bus.busy, bus.done, bus.b, bus.exact, bus.err); end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midop_no_done: got %0d done cycles want 0", seen); end
        do_op(13, 5, b, e, er, lat);
        checks++; if (b !== 12 || e !== 1 || er !== 0 || lat !== LAT) begin errors++;
            $display("FAIL midop_fresh: got b=%0d exact=%0d err=%0d lat=%0d want 12 1 0 %0d", b, e, er, lat, LAT); end
    endtask

    task automatic test_sweep();
        int b, e, er, lat, d, r, ex;
        for (int hv = 0; hv <= 255; hv += 15) begin
            for (int av = 0; av <= hv; av += 3) begin
                do_op(hv, av, b, e, er, lat);
                d  = hv * hv - av * av;
                r  = isqrt(d);
                ex = (r * r == d) ? 1 : 0;
                checks++; if (b !== r || e !== ex || er !== 0 || lat !== LAT) begin errors++;
                    $display("FAIL sweep h=%0d a=%0d: got b=%0d exact=%0d err=%0d lat=%0d want %0d %0d 0 %0d",
                             hv, av, b, e, er, lat, r, ex, LAT); end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.h     = '0;
        bus.a     = '0;

        test_reset();
        test_basic();
        test_extremes();
        test_nonsquare_err();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        test_sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
